// File: rtl/pixel_cfg_pkg.sv
// Shared pixel-config definitions: receiver FSM encoding and the default
// stretch parameters agreed with the pulse stretcher on the transmit side.
package pixel_cfg_pkg;

  // Default stretched width; must match the stretcher's setting.
  localparam int unsigned DefaultPulseLength = 3;
  // Shortest pulse treated as real rather than a glitch.
  localparam int unsigned DefaultMinWidth    = 2;
  // Width of the measurement counter.
  localparam int unsigned DefaultCntW        = 8;

  // StArm waits for a known-low input so that a pulse which is already high
  // when reset is released is never measured.
  typedef enum logic [1:0] {
    StArm     = 2'd0,
    StIdle    = 2'd1,
    StMeasure = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_width_decoder_if.sv
// Pulse-in / measurement-out bundle of the pulse width decoder.
// The slave modport is the decoder side; master is the pulse source / consumer.
interface pulse_width_decoder_if #(
  parameter int unsigned CNT_W = pixel_cfg_pkg::DefaultCntW
);

  logic             pulse_in;
  logic             pulse_out;
  logic             width_valid;
  logic [CNT_W-1:0] width_out;
  logic             width_match;
  logic             overflow;
  logic             glitch_out;

  modport master (
    output pulse_in,
    input  pulse_out,
    input  width_valid,
    input  width_out,
    input  width_match,
    input  overflow,
    input  glitch_out
  );

  modport slave (
    input  pulse_in,
    output pulse_out,
    output width_valid,
    output width_out,
    output width_match,
    output overflow,
    output glitch_out
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high reset to 0.
// Reusable by any pixel-config receiver that samples a foreign-domain level.
module sync_2ff (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second resolves it.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pulse_width_decoder.sv
// Pulse width decoder: measures a stretched pulse in clk_in cycles, collapses
// it to a one-cycle strobe, and reports width, match against the expected
// stretch length and counter saturation. Runt pulses raise glitch_out instead.
module pulse_width_decoder
  import pixel_cfg_pkg::*;
#(
  parameter int unsigned PULSE_LENGTH = DefaultPulseLength,
  parameter int unsigned MIN_WIDTH    = DefaultMinWidth,
  parameter int unsigned CNT_W        = DefaultCntW
) (
  input logic                 clk_in,
  input logic                 rst,
  pulse_width_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MinW     = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] PulseLen = CNT_W'(PULSE_LENGTH);

  // Reject parameter sets that cannot be measured consistently.
  if (MIN_WIDTH < 1) begin : gen_bad_min_width
    $error("pulse_width_decoder: MIN_WIDTH must be at least 1");
  end
  if (PULSE_LENGTH < MIN_WIDTH) begin : gen_bad_pulse_length_low
    $error("pulse_width_decoder: PULSE_LENGTH must be >= MIN_WIDTH");
  end
  if (64'(PULSE_LENGTH) > ((64'(1) << CNT_W) - 64'(1))) begin : gen_bad_pulse_length_high
    $error("pulse_width_decoder: PULSE_LENGTH must fit in CNT_W bits");
  end

  logic             s;
  logic [1:0]       prime_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             pulse_q, pulse_d;
  logic             valid_q, valid_d;
  logic             glitch_q, glitch_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             match_q, match_d;
  logic             ovf_q, ovf_d;

  sync_2ff u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (bus.pulse_in),
    .q      (s)
  );

  // Tracks when the synchronizer holds a real sample rather than its reset 0,
  // so that StArm cannot mistake the reset value for a low input.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      prime_q <= 2'b00;
    end else begin
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= StArm;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      pulse_q  <= 1'b0;
      valid_q  <= 1'b0;
      glitch_q <= 1'b0;
      width_q  <= '0;
      match_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      pulse_q  <= pulse_d;
      valid_q  <= valid_d;
      glitch_q <= glitch_d;
      width_q  <= width_d;
      match_q  <= match_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state, measurement and strobe generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    pulse_d  = 1'b0;
    valid_d  = 1'b0;
    glitch_d = 1'b0;
    width_d  = width_q;
    match_d  = match_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StArm: begin
        if (prime_q[1] && !s) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (s) begin
          state_d = StMeasure;
          cnt_d   = CntOne;
          sat_d   = 1'b0;
        end
      end
      StMeasure: begin
        if (s) begin
          if (cnt_q == CntMax) begin
            sat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else begin
          // Leaving through StIdle lets a 1-cycle low gap separate two pulses.
          state_d = StIdle;
          if (cnt_q >= MinW) begin
            pulse_d = 1'b1;
            valid_d = 1'b1;
            width_d = cnt_q;
            match_d = (cnt_q == PulseLen);
            ovf_d   = sat_q;
          end else begin
            glitch_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StArm;
      end
    endcase
  end

  assign bus.pulse_out   = pulse_q;
  assign bus.width_valid = valid_q;
  assign bus.glitch_out  = glitch_q;
  assign bus.width_out   = width_q;
  assign bus.width_match = match_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Self-checking bench for pulse_width_decoder: table-driven pulse vectors
// feeding a scoreboard, plus hand-written reset and async-edge sequences.
module tb_pulse_width_decoder;

  localparam int unsigned PulseLength = 3;
  localparam int unsigned MinWidth    = 2;
  localparam int unsigned CntW        = 8;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  pulse_width_decoder_if #(.CNT_W(CntW)) bus ();

  pulse_width_decoder #(
    .PULSE_LENGTH (PulseLength),
    .MIN_WIDTH    (MinWidth),
    .CNT_W        (CntW)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int unsigned high;
    int unsigned low;
    bit          glitch;
    int unsigned width;
    bit          match;
    bit          ovf;
  } vec_t;

  typedef struct {
    bit          glitch;
    int unsigned width;
    bit          match;
    bit          ovf;
    bit          loose;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_width = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Hold pulse_in high for 'high' sampling edges, then low for 'low' edges.
  task automatic drive(input int unsigned high, input int unsigned low);
    bus.pulse_in = 1'b1;
    repeat (high) @(negedge clk_in);
    bus.pulse_in = 1'b0;
    repeat (low) @(negedge clk_in);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk_in);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    bit   prev_strobe;
    bit   strobe;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk_in);
      if (rst) begin
        prev_strobe = 1'b0;
      end else begin
        if ($isunknown({bus.pulse_out, bus.width_valid, bus.glitch_out, bus.width_out,
                        bus.width_match, bus.overflow}))
          check("outputs_known", 0, 1);
        if (bus.pulse_out != bus.width_valid)
          check("valid_tracks_pulse", int'(bus.width_valid), int'(bus.pulse_out));
        strobe = bus.pulse_out | bus.glitch_out;
        if (strobe) begin
          check("strobe_gap", int'(prev_strobe), 0);
          check("single_strobe_kind", int'(bus.pulse_out & bus.glitch_out), 0);
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_strobe: got pulse_out=%0b glitch_out=%0b expected none (cycle %0d)",
                     bus.pulse_out, bus.glitch_out, cyc);
          end else begin
            e = sb.pop_front();
            check("glitch_kind", int'(bus.glitch_out), int'(e.glitch));
            if (e.cyc >= 0) check("strobe_latency", cyc, e.cyc);
            if (e.glitch) begin
              check("glitch_holds_width", int'(bus.width_out), last_width);
            end else if (e.loose) begin
              check("async_width_3_or_4", int'(int'(bus.width_out) inside {3, 4}), 1);
              check("async_match", int'(bus.width_match), int'(int'(bus.width_out) == PulseLength));
              check("async_overflow", int'(bus.overflow), 0);
            end else begin
              check("width_out", int'(bus.width_out), int'(e.width));
              check("width_match", int'(bus.width_match), int'(e.match));
              check("overflow", int'(bus.overflow), int'(e.ovf));
              last_width = int'(e.width);
            end
          end
        end
        prev_strobe = strobe;
      end
    end
  end

  initial begin : stimulus
    vec_t vecs[10];
    exp_t e;

    // {high, low, glitch, width, match, ovf}
    vecs[0] = '{3,   6, 1'b0, 3,   1'b1, 1'b0};
    vecs[1] = '{1,   6, 1'b1, 0,   1'b0, 1'b0};
    vecs[2] = '{300, 6, 1'b0, 255, 1'b0, 1'b1};
    vecs[3] = '{4,   1, 1'b0, 4,   1'b0, 1'b0};
    vecs[4] = '{5,   1, 1'b0, 5,   1'b0, 1'b0};
    vecs[5] = '{3,   6, 1'b0, 3,   1'b1, 1'b0};
    vecs[6] = '{4,   6, 1'b0, 4,   1'b0, 1'b0};
    vecs[7] = '{2,   6, 1'b0, 2,   1'b0, 1'b0};
    vecs[8] = '{255, 6, 1'b0, 255, 1'b0, 1'b0};
    vecs[9] = '{256, 6, 1'b0, 255, 1'b0, 1'b1};

    bus.pulse_in = 1'b0;
    #50;
    check("reset_pulse_out", int'(bus.pulse_out), 0);
    check("reset_width_valid", int'(bus.width_valid), 0);
    check("reset_width_out", int'(bus.width_out), 0);
    check("reset_width_match", int'(bus.width_match), 0);
    check("reset_overflow", int'(bus.overflow), 0);
    check("reset_glitch_out", int'(bus.glitch_out), 0);
    #50 rst = 1'b0;
    repeat (5) @(negedge clk_in);

    for (int i = 0; i < 10; i++) begin
      e.glitch = vecs[i].glitch;
      e.width  = vecs[i].width;
      e.match  = vecs[i].match;
      e.ovf    = vecs[i].ovf;
      e.loose  = 1'b0;
      e.cyc    = cyc + int'(vecs[i].high) + 3;
      sb.push_back(e);
      drive(vecs[i].high, vecs[i].low);
    end
    drain();

    // Reset in the middle of a pulse; the remainder must not be measured.
    bus.pulse_in = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    #2 rst = 1'b1;
    #1;
    check("midrst_width_out", int'(bus.width_out), 0);
    check("midrst_overflow", int'(bus.overflow), 0);
    check("midrst_width_match", int'(bus.width_match), 0);
    check("midrst_pulse_out", int'(bus.pulse_out), 0);
    check("midrst_glitch_out", int'(bus.glitch_out), 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    repeat (4) @(negedge clk_in);
    bus.pulse_in = 1'b0;
    repeat (8) @(negedge clk_in);

    e.glitch = 1'b0;
    e.width  = 3;
    e.match  = 1'b1;
    e.ovf    = 1'b0;
    e.loose  = 1'b0;
    e.cyc    = cyc + 3 + 3;
    sb.push_back(e);
    drive(3, 6);
    drain();

    // Pulse edges placed 1 ns before the sampling edge.
    e.loose = 1'b1;
    e.cyc   = -1;
    sb.push_back(e);
    @(posedge clk_in);
    #9 bus.pulse_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #9 bus.pulse_in = 1'b0;
    repeat (8) @(negedge clk_in);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_width_decoder.md
Name: pulse_width_decoder

Overview:
- Receive-side counterpart of the pixel-config pulse stretcher.
- Takes a stretched (multi-cycle) pulse and measures its width in clk_in cycles. It then collapses the pulse back to a single-cycle strobe and reports the width, whether it matches the expected stretch length, and any overflow.
- Sits downstream of stretched strobes crossing into the readout/config domain; runt (glitch) pulses are filtered.

Parameters:
- PULSE_LENGTH, 3, expected stretched width in cycles; drives width_match.
- MIN_WIDTH, 2, minimum width accepted as a real pulse; shorter pulses are glitches.
- CNT_W, 8, width of the measurement counter and width_out; saturates at 2^CNT_W-1.

Ports:
- clk_in, input, 1, single system clock, rising edge.
- rst, input, 1, asynchronous, active-high reset.
- pulse_in, input, 1, stretched pulse; may be asynchronous to clk_in.
- pulse_out, output, 1, one-cycle strobe per accepted pulse.
- width_valid, output, 1, one-cycle qualifier for width_out / width_match / overflow; coincident with pulse_out.
- width_out, output, CNT_W, measured width in cycles; held until the next accepted pulse.
- width_match, output, 1, width_out == PULSE_LENGTH; held like width_out.
- overflow, output, 1, measurement saturated; held like width_out.
- glitch_out, output, 1, one-cycle strobe when a pulse shorter than MIN_WIDTH is dropped.

Behaviour:
- Reset:
  - Asynchronous reset clears all outputs and the synchronizer flops to 0, and the counter to 0.
  - FSM goes to ARM.
- Synchronizer:
  - 2-flop synchronizer on pulse_in; s = second stage.
  - Every decision below uses s, never pulse_in directly.
- FSM states: ARM, IDLE, MEASURE.
  - ARM: wait for s==0, then go to IDLE. A pulse already high at reset release is never measured.
  - IDLE: if s==1, go to MEASURE and set cnt=1.
  - MEASURE, s==1: cnt<=cnt+1, saturating at 2^CNT_W-1; set sat flag when an increment is attempted at max.
  - MEASURE, s==0, cnt>=MIN_WIDTH: register width_out=cnt, width_match=(cnt==PULSE_LENGTH), overflow=sat. Pulse pulse_out and width_valid for one cycle, then go to IDLE.
  - MEASURE, s==0, cnt<MIN_WIDTH: pulse glitch_out for one cycle. width_out, width_match and overflow are unchanged. Go to IDLE.
- Width arithmetic:
  - A pulse sampled high on N consecutive edges gives cnt==N, saturating at 2^CNT_W-1.
- Latency:
  - pulse_out / width_valid go high after the 2nd clk_in edge following the first edge that samples pulse_in low.
  - They stay high for exactly one cycle.
- Back-to-back pulses:
  - A low gap of 1 sampled cycle is enough to separate two pulses.
  - The FSM returns to IDLE and re-enters MEASURE on the next edge with no lost cycle.
- Strobe independence:
  - pulse_out and glitch_out are never high in the same cycle.
  - Consecutive strobes are separated by at least 1 low cycle.
- Reset mid-pulse:
  - All outputs drop immediately and the partial measurement is discarded.
  - After release, ARM suppresses the remainder of the pulse.
- MIN_WIDTH=1 disables glitch filtering.
- PULSE_LENGTH must satisfy PULSE_LENGTH >= MIN_WIDTH and PULSE_LENGTH <= 2^CNT_W-1. An illegal value is an elaboration error.

Decomposition:
- Shared package pixel_cfg_pkg: FSM state encoding (ARM/IDLE/MEASURE) and a default-width constant shared with the stretcher (PULSE_LENGTH default 3).
- One sub-module: sync_2ff, the 2-flop synchronizer with async active-high reset to 0. It is reusable by other pixel-config receivers.
- Remaining logic (FSM, counter, output registers) lives in pulse_width_decoder.

Test Plan:
- 10 ns clk_in, rst high 0-100 ns. pulse_in high for 30 ns (3 edges) -> one-cycle pulse_out/width_valid 2 edges after first low sample; width_out=3, width_match=1, overflow=0.
- pulse_in high 10 ns (1 edge), MIN_WIDTH=2 -> glitch_out one cycle; pulse_out/width_valid stay 0; width_out keeps its previous value.
- pulse_in high 3000 ns (300 edges), CNT_W=8 -> width_out=255, overflow=1, width_match=0, single pulse_out.
- Three-pulse train: high 4, low 1, high 5, low 1, high 3 cycles -> three width_valid strobes, each one cycle with at least 1 low cycle between. width_out=4 (match 0), then 5 (match 0), then 3 (match 1); no glitch_out.
- Reset mid-pulse: rst asserted after pulse_in high 2 edges, released while pulse_in still high -> all outputs 0 at once, no strobe for that pulse. A following 3-cycle pulse -> width_out=3.
- pulse_in high 4 cycles with PULSE_LENGTH=3 -> width_out=4, width_match=0; then an async pulse_in edge placed 1 ns before a clk_in edge is still measured (width 3 or 4) with no X on the outputs.
